// File: rtl/list_arbiter.sv
// Two-client arbiter sharing one upstream list iterator. Each client request
// fetches the next element; once the list is exhausted, clients get invalid answers locally.
module list_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ready,
  output logic             list_req,
  input  logic             list_ack,
  input  logic [WIDTH-1:0] list_value,
  input  logic             list_value_valid,
  input  logic             clientA_req,
  input  logic             clientB_req,
  output logic             clientA_ack,
  output logic             clientB_ack,
  output logic [WIDTH-1:0] clientA_value,
  output logic [WIDTH-1:0] clientB_value,
  output logic             clientA_value_valid,
  output logic             clientB_value_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t state;
  logic   grant_b;
  logic   prio_b;
  logic   pend_a;
  logic   pend_b;
  logic   exhausted;
  logic   req_a_q;
  logic   req_b_q;

  logic   edge_a;
  logic   edge_b;
  logic   pick_b;
  logic   any_pend;

  assign edge_a   = clientA_req & ~req_a_q;
  assign edge_b   = clientB_req & ~req_b_q;
  assign any_pend = pend_a | pend_b;
  assign pick_b   = (pend_a & pend_b) ? prio_b : pend_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      grant_b             <= 1'b0;
      prio_b              <= 1'b0;
      pend_a              <= 1'b0;
      pend_b              <= 1'b0;
      exhausted           <= 1'b0;
      req_a_q             <= 1'b0;
      req_b_q             <= 1'b0;
      list_req            <= 1'b0;
      clientA_ack         <= 1'b0;
      clientB_ack         <= 1'b0;
      clientA_value       <= '0;
      clientB_value       <= '0;
      clientA_value_valid <= 1'b0;
      clientB_value_valid <= 1'b0;
    end else begin
      req_a_q     <= clientA_req;
      req_b_q     <= clientB_req;
      clientA_ack <= 1'b0;
      clientB_ack <= 1'b0;
      if (!ready) begin
        state               <= IDLE;
        prio_b              <= 1'b0;
        pend_a              <= 1'b0;
        pend_b              <= 1'b0;
        exhausted           <= 1'b0;
        list_req            <= 1'b0;
        clientA_value_valid <= 1'b0;
        clientB_value_valid <= 1'b0;
      end else begin
        // Edges while a flag is already set fold into it; clears below win.
        pend_a <= pend_a | edge_a;
        pend_b <= pend_b | edge_b;
        case (state)
          IDLE: begin
            if (any_pend) begin
              grant_b <= pick_b;
              if (exhausted) begin
                // Answer locally: ack with an invalid element, list untouched.
                prio_b <= ~prio_b;
                if (pick_b) begin
                  clientB_ack         <= 1'b1;
                  clientB_value_valid <= 1'b0;
                  pend_b              <= 1'b0;
                end else begin
                  clientA_ack         <= 1'b1;
                  clientA_value_valid <= 1'b0;
                  pend_a              <= 1'b0;
                end
              end else begin
                state    <= ISSUE;
                list_req <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (list_ack) begin
              list_req <= 1'b0;
              state    <= GAP;
              prio_b   <= ~grant_b;
              if (!list_value_valid) exhausted <= 1'b1;
              if (grant_b) begin
                clientB_ack         <= 1'b1;
                clientB_value       <= list_value;
                clientB_value_valid <= list_value_valid;
                pend_b              <= 1'b0;
              end else begin
                clientA_ack         <= 1'b1;
                clientA_value       <= list_value;
                clientA_value_valid <= list_value_valid;
                pend_a              <= 1'b0;
              end
            end
          end
          GAP:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/list_arbiter.md
LIST_ARBITER -- requirements
Module: list_arbiter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, value width of every list element.
REQ-002 The block SHALL have these ports, in this order:
- clock  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ready  in  1  active-high enable; low behaves as a synchronous clear.
- list_req  out  1  request to the shared upstream list.
- list_ack  in  1  upstream one-cycle acknowledge.
- list_value  in  WIDTH  upstream element.
- list_value_valid  in  1  upstream element valid; 0 means list exhausted.
- clientA_req / clientB_req  in  1  client requests; rising-edge significant.
- clientA_ack / clientB_ack  out  1  one-cycle registered acknowledges.
- clientA_value / clientB_value  out  WIDTH  registered element returned to the client.
- clientA_value_valid / clientB_value_valid  out  1  registered element valid.

Function
REQ-003 The block SHALL register each client_req every cycle and detect a rising edge as req=1 with the previous sample 0.
REQ-004 A detected edge SHALL set that client's pending flag at the next clock edge. An edge is ignored while that client's flag is already set, so each client has at most one outstanding request.
REQ-005 The FSM SHALL have three states, IDLE, ISSUE and GAP, plus a grant register (A or B) and a priority pointer that resets to A.
REQ-006 IDLE, no pending flag set: remain in IDLE with list_req=0.
REQ-007 IDLE, exactly one flag set: grant that client.
REQ-008 IDLE, both flags set: grant the client named by the priority pointer.
REQ-009 IDLE, exhausted flag clear: on granting, move to ISSUE and register list_req=1.
REQ-010 IDLE, exhausted flag set: on granting, pulse the granted client's ack for one cycle with value_valid=0 and value unchanged, without raising list_req. Then clear that client's pending flag, toggle the priority pointer and stay in IDLE.
REQ-011 ISSUE SHALL hold list_req=1 until list_ack is sampled high. No timeout is applied.
REQ-012 ISSUE, list_ack sampled high: on that edge, deassert list_req and copy list_value and list_value_valid into the granted client's value registers.
- Also on that edge: pulse the granted client's ack (visible the cycle after list_ack), clear its pending flag, set the priority pointer to the other client, and enter GAP.
REQ-013 The exhausted flag SHALL be set when list_ack is sampled high with list_value_valid=0.
REQ-014 GAP SHALL last exactly one cycle with list_req=0, then return to IDLE, so each upstream request presents a fresh rising edge.
REQ-015 Every client ack pulse SHALL last exactly one cycle; clientA_ack and clientB_ack SHALL never be high in the same cycle.
REQ-016 The non-granted client's value and value_valid SHALL hold their previous values.
REQ-017 Client edges arriving during ISSUE or GAP SHALL be recorded as pending and served in later IDLE cycles.
REQ-018 When ready=0, the block SHALL on each clock edge:
- clear both pending flags and the exhausted flag;
- force the FSM to IDLE, list_req=0 and both acks 0;
- reset the priority pointer to A and clear both value_valid outputs;
- still sample client_req.
REQ-019 Deasserting ready mid-ISSUE SHALL abort the transaction: no client ack is issued for it, and a late list_ack is ignored.
REQ-020 Upstream latency SHALL be: client edge at cycle 0 -> list_req high from cycle 2; list_ack at cycle k -> client ack at cycle k+1.

Reset
REQ-021 While reset_n=0, asynchronously and independently of clock, the block SHALL:
- force list_req, both acks and both value_valid outputs to 0, and both values to 0;
- clear both pending flags, the exhausted flag and both sampled-req registers;
- put the FSM in IDLE with the priority pointer at A.
REQ-022 After reset_n rises, operation SHALL begin on the first clock edge with ready=1.

Verification
REQ-023 Single client: upstream enum min=1 step=2 max=5; clientA requests four times. clientA SHALL receive (1,1), (3,1), (5,1), (x,0). A fifth request SHALL get value_valid=0 with no list_req edge.
REQ-024 Simultaneous: both clients raise req in the same cycle after reset. A SHALL be served first (value 1) and B second (value 3).
REQ-025 Round-robin: with A and B requesting continuously, upstream grants SHALL alternate A, B, A, B.
REQ-026 Gap: each pair of consecutive list_req high periods SHALL be separated by at least one low cycle. Each upstream element SHALL be delivered to exactly one client.
REQ-027 Abort: drop ready while in ISSUE, then raise list_ack the next cycle. No client ack SHALL occur. After ready=1, a new A request SHALL restart the enum at value 1.
REQ-028 Async reset: assert reset_n=0 between clock edges while in ISSUE. list_req SHALL go to 0 immediately, before the next clock edge.
